// File: rtl/pio_loader.sv
// PIO program loader: streams up to 32 program words into a PIO block and then
// issues the PEND/DIV/GRPS/EN(/IMM) configuration actions for one state machine.
module pio_loader (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  plen,
  input  logic [1:0]  sm_sel,
  input  logic [31:0] exec_ctrl,
  input  logic [23:0] div,
  input  logic [31:0] pin_grps,
  input  logic [3:0]  en_mask,
  input  logic        imm_en,
  input  logic [15:0] imm_instr,
  output logic [4:0]  prog_addr,
  input  logic [15:0] prog_data,
  output logic [3:0]  action,
  output logic [4:0]  index,
  output logic [1:0]  mindex,
  output logic [31:0] din,
  output logic        busy,
  output logic        done
);

  localparam int DATA_W = 32;

  localparam logic [3:0] ACT_NONE  = 4'd0;
  localparam logic [3:0] ACT_INSTR = 4'd1;
  localparam logic [3:0] ACT_PEND  = 4'd2;
  localparam logic [3:0] ACT_GRPS  = 4'd5;
  localparam logic [3:0] ACT_EN    = 4'd6;
  localparam logic [3:0] ACT_DIV   = 4'd7;
  localparam logic [3:0] ACT_IMM   = 4'd9;

  typedef enum logic [3:0] {
    IDLE, FETCH, INSTR, PEND, DIV, GRPS, EN, IMM, DONE
  } state_t;

  function automatic logic [5:0] clamp_plen(input logic [5:0] len);
    return (len > 6'd32) ? 6'd32 : len;
  endfunction

  state_t              state_q;
  state_t              state_d;
  logic [4:0]          cnt_q;
  logic                accept;
  logic                more_instr;

  logic [5:0]          cfg_plen;
  logic [31:0]         cfg_exec;
  logic [23:0]         cfg_div;
  logic [31:0]         cfg_grps;
  logic [3:0]          cfg_en;
  logic                cfg_imm_en;
  logic [15:0]         cfg_imm;

  logic [3:0]          act_p0;
  logic [DATA_W-1:0]   din_p0;
  logic [3:0]          action_p1;
  logic [DATA_W-1:0]   din_p1;
  logic [4:0]          index_p1;
  logic [1:0]          mindex_p1;
  logic                busy_p1;
  logic                done_p1;

  assign accept     = (state_q == IDLE) && start;
  assign more_instr = ({1'b0, cnt_q} + 6'd1) < cfg_plen;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (clamp_plen(plen) != 6'd0) ? FETCH : PEND;
      FETCH:   state_d = INSTR;
      INSTR:   state_d = more_instr ? FETCH : PEND;
      PEND:    state_d = DIV;
      DIV:     state_d = GRPS;
      GRPS:    state_d = EN;
      EN:      state_d = cfg_imm_en ? IMM : DONE;
      IMM:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage p0: decode the action for the current state. prog_data for slot i
  // arrives during INSTR, so every action leaves the output register one
  // cycle after its state.
  always_comb begin
    act_p0 = ACT_NONE;
    din_p0 = '0;
    case (state_q)
      INSTR: begin act_p0 = ACT_INSTR; din_p0 = {16'h0, prog_data}; end
      PEND:  begin act_p0 = ACT_PEND;  din_p0 = cfg_exec;           end
      DIV:   begin act_p0 = ACT_DIV;   din_p0 = {8'h0, cfg_div};     end
      GRPS:  begin act_p0 = ACT_GRPS;  din_p0 = cfg_grps;           end
      EN:    begin act_p0 = ACT_EN;    din_p0 = {28'h0, cfg_en};     end
      IMM:   begin act_p0 = ACT_IMM;   din_p0 = {16'h0, cfg_imm};    end
      default: ;
    endcase
  end

  // Configuration snapshot taken only on an accepted start.
  always_ff @(posedge clk) begin
    if (accept) begin
      cfg_plen   <= clamp_plen(plen);
      cfg_exec   <= exec_ctrl;
      cfg_div    <= div;
      cfg_grps   <= pin_grps;
      cfg_en     <= en_mask;
      cfg_imm_en <= imm_en;
      cfg_imm    <= imm_instr;
    end
  end

  // Stage p1: registered outputs and sequencing state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      action_p1 <= ACT_NONE;
      din_p1    <= '0;
      index_p1  <= '0;
      mindex_p1 <= '0;
      busy_p1   <= 1'b0;
      done_p1   <= 1'b0;
    end else begin
      state_q   <= state_d;
      if (accept)
        cnt_q <= '0;
      else if (state_q == INSTR && more_instr)
        cnt_q <= cnt_q + 5'd1;
      action_p1 <= act_p0;
      din_p1    <= din_p0;
      if (state_q == INSTR)
        index_p1 <= cnt_q;
      if (accept)
        mindex_p1 <= sm_sel;
      busy_p1   <= (state_d != IDLE) && (state_d != DONE);
      done_p1   <= (state_q == DONE);
    end
  end

  assign prog_addr = cnt_q;
  assign action    = action_p1;
  assign din       = din_p1;
  assign index     = index_p1;
  assign mindex    = mindex_p1;
  assign busy      = busy_p1;
  assign done      = done_p1;

endmodule

// File: tb/tb_pio_loader.sv
// Scoreboard bench for pio_loader: expected actions are queued when a start is
// accepted and compared, with their cycle offset, as the loader issues them.
module tb_pio_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  plen;
  logic [1:0]  sm_sel;
  logic [31:0] exec_ctrl;
  logic [23:0] div;
  logic [31:0] pin_grps;
  logic [3:0]  en_mask;
  logic        imm_en;
  logic [15:0] imm_instr;
  logic [4:0]  prog_addr;
  logic [15:0] prog_data;
  logic [3:0]  action;
  logic [4:0]  index;
  logic [1:0]  mindex;
  logic [31:0] din;
  logic        busy;
  logic        done;

  pio_loader dut (
    .clk(clk), .reset(reset), .start(start), .plen(plen), .sm_sel(sm_sel),
    .exec_ctrl(exec_ctrl), .div(div), .pin_grps(pin_grps), .en_mask(en_mask),
    .imm_en(imm_en), .imm_instr(imm_instr), .prog_addr(prog_addr),
    .prog_data(prog_data), .action(action), .index(index), .mindex(mindex),
    .din(din), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [32];
  always @(posedge clk) prog_data <= mem[prog_addr];

  typedef struct {
    logic [3:0]  act;
    logic [4:0]  idx;
    logic [31:0] din;
    int          rel;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  int          busy_last;
  int          done_rel;
  logic [1:0]  exp_mindex;
  logic [4:0]  last_idx = 5'd0;

  // Pulses start, then queues the expected action stream using the bench's own
  // copy of the configuration and program memory; r=0 is the first cycle after
  // the accepting edge. Inputs are scrambled afterwards to prove they were latched.
  task automatic drive_start(input int p_raw, input bit imm, input logic [1:0] sm);
    int p;
    p = (p_raw > 32) ? 32 : p_raw;
    @(negedge clk);
    plen = p_raw[5:0]; imm_en = imm; sm_sel = sm; start = 1'b1;
    @(posedge clk);
    #1;
    start      = 1'b0;
    exp_mindex = sm;
    busy_last  = 2 * p + 3 + int'(imm);
    done_rel   = 2 * p + 5 + int'(imm);
    for (int k = 0; k < p; k++)
      sbq.push_back('{4'd1, 5'(k), {16'h0, mem[k]}, 2 + 2 * k});
    if (p > 0) last_idx = 5'(p - 1);
    sbq.push_back('{4'd2, last_idx, exec_ctrl, 1 + 2 * p});
    sbq.push_back('{4'd7, last_idx, {8'h0, div}, 2 + 2 * p});
    sbq.push_back('{4'd5, last_idx, pin_grps, 3 + 2 * p});
    sbq.push_back('{4'd6, last_idx, {28'h0, en_mask}, 4 + 2 * p});
    if (imm) sbq.push_back('{4'd9, last_idx, {16'h0, imm_instr}, 5 + 2 * p});
    plen = 6'($urandom); exec_ctrl = $urandom; div = 24'($urandom);
    pin_grps = $urandom; en_mask = 4'($urandom); imm_en = 1'($urandom);
    imm_instr = 16'($urandom); sm_sel = 2'($urandom);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (action !== 4'd0 || din !== 32'h0 || index !== 5'd0 || mindex !== 2'd0 ||
        prog_addr !== 5'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state act=%0d din=%h idx=%0d mi=%0d pa=%0d busy=%b done=%b, all required zero",
               action, din, index, mindex, prog_addr, busy, done);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (action !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset act=%0d busy=%b done=%b, required 0/0/0", action, busy, done);
    end
  endtask

  task automatic test_basic();
    exp_t e;
    mem[0] = 16'hE081; mem[1] = 16'h0000;
    exec_ctrl = 32'h0000_1000; div = 24'h000280; pin_grps = 32'h0400_0000;
    en_mask = 4'd1; imm_instr = 16'h0;
    drive_start(2, 1'b0, 2'd1);
    for (int r = 0; r <= done_rel + 2; r++) begin
      @(negedge clk);
      checks++;
      if (action !== 4'd0) begin
        if (sbq.size() == 0) begin
          errors++; $display("FAIL basic_extra r=%0d act=%0d, required none", r, action);
        end else begin
          e = sbq.pop_front();
          if (action !== e.act || index !== e.idx || din !== e.din || mindex !== exp_mindex || r != e.rel) begin
            errors++;
            $display("FAIL basic_issue r=%0d act=%0d idx=%0d din=%h mi=%0d, required act=%0d idx=%0d din=%h mi=%0d r=%0d",
                     r, action, index, din, mindex, e.act, e.idx, e.din, exp_mindex, e.rel);
          end
        end
      end else if (din !== 32'h0) begin
        errors++; $display("FAIL basic_idle_din r=%0d din=%h, required 0", r, din);
      end
      checks++;
      if (busy !== (r <= busy_last) || done !== (r == done_rel)) begin
        errors++; $display("FAIL basic_busy_done r=%0d busy=%b done=%b, required %b %b", r, busy, done, r <= busy_last, r == done_rel);
      end
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++; $display("FAIL basic_missing %0d actions never issued, required 0", sbq.size()); sbq.delete();
    end
  endtask

  task automatic test_plen0();
    exp_t e;
    exec_ctrl = 32'hDEAD_0001; div = 24'hFFFFFF; pin_grps = 32'h1234_5678;
    en_mask = 4'hF; imm_instr = 16'h0;
    drive_start(0, 1'b0, 2'd2);
    for (int r = 0; r <= done_rel + 2; r++) begin
      @(negedge clk);
      checks++;
      if (action !== 4'd0) begin
        if (sbq.size() == 0) begin
          errors++; $display("FAIL plen0_extra r=%0d act=%0d, required none", r, action);
        end else begin
          e = sbq.pop_front();
          if (action !== e.act || index !== e.idx || din !== e.din || mindex !== exp_mindex || r != e.rel) begin
            errors++;
            $display("FAIL plen0_issue r=%0d act=%0d idx=%0d din=%h mi=%0d, required act=%0d idx=%0d din=%h mi=%0d r=%0d",
                     r, action, index, din, mindex, e.act, e.idx, e.din, exp_mindex, e.rel);
          end
        end
      end
      checks++;
      if (busy !== (r <= busy_last) || done !== (r == done_rel)) begin
        errors++; $display("FAIL plen0_busy_done r=%0d busy=%b done=%b, required %b %b", r, busy, done, r <= busy_last, r == done_rel);
      end
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++; $display("FAIL plen0_missing %0d actions never issued, required 0", sbq.size()); sbq.delete();
    end
  endtask

  task automatic test_clamp_imm();
    exp_t e;
    for (int k = 0; k < 32; k++) mem[k] = 16'hC000 + 16'(k * 7);
    exec_ctrl = 32'h0000_2000; div = 24'h010000; pin_grps = 32'h8000_0001;
    en_mask = 4'd4; imm_instr = 16'hE001;
    drive_start(40, 1'b1, 2'd0);
    for (int r = 0; r <= done_rel + 2; r++) begin
      @(negedge clk);
      checks++;
      if (action !== 4'd0) begin
        if (sbq.size() == 0) begin
          errors++; $display("FAIL clamp_extra r=%0d act=%0d idx=%0d, required none", r, action, index);
        end else begin
          e = sbq.pop_front();
          if (action !== e.act || index !== e.idx || din !== e.din || mindex !== exp_mindex || r != e.rel) begin
            errors++;
            $display("FAIL clamp_issue r=%0d act=%0d idx=%0d din=%h mi=%0d, required act=%0d idx=%0d din=%h mi=%0d r=%0d",
                     r, action, index, din, mindex, e.act, e.idx, e.din, exp_mindex, e.rel);
          end
        end
      end
      checks++;
      if (busy !== (r <= busy_last) || done !== (r == done_rel)) begin
        errors++; $display("FAIL clamp_busy_done r=%0d busy=%b done=%b, required %b %b", r, busy, done, r <= busy_last, r == done_rel);
      end
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++; $display("FAIL clamp_missing %0d actions never issued, required 0", sbq.size()); sbq.delete();
    end
  endtask

  task automatic test_start_ignored();
    exp_t e;
    exec_ctrl = 32'h0BAD_F00D; div = 24'h000003; pin_grps = 32'h0000_FFFF;
    en_mask = 4'd2; imm_instr = 16'h0;
    drive_start(5, 1'b0, 2'd1);
    for (int r = 0; r <= done_rel + 2; r++) begin
      @(negedge clk);
      checks++;
      if (action !== 4'd0) begin
        if (sbq.size() == 0) begin
          errors++; $display("FAIL ignore_extra r=%0d act=%0d, required none", r, action);
        end else begin
          e = sbq.pop_front();
          if (action !== e.act || index !== e.idx || din !== e.din || mindex !== exp_mindex || r != e.rel) begin
            errors++;
            $display("FAIL ignore_issue r=%0d act=%0d idx=%0d din=%h mi=%0d, required act=%0d idx=%0d din=%h mi=%0d r=%0d",
                     r, action, index, din, mindex, e.act, e.idx, e.din, exp_mindex, e.rel);
          end
        end
      end
      checks++;
      if (busy !== (r <= busy_last) || done !== (r == done_rel)) begin
        errors++; $display("FAIL ignore_busy_done r=%0d busy=%b done=%b, required %b %b", r, busy, done, r <= busy_last, r == done_rel);
      end
      start = (r == 3);
      if (r == 3) plen = 6'd1;
    end
    start = 1'b0;
    checks++;
    if (sbq.size() != 0) begin
      errors++; $display("FAIL ignore_missing %0d actions never issued, required 0", sbq.size()); sbq.delete();
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    exec_ctrl = 32'h1111_2222; div = 24'h000055; pin_grps = 32'h3;
    en_mask = 4'd8; imm_instr = 16'h0;
    drive_start(0, 1'b0, 2'd2);
    repeat (3) @(negedge clk);
    checks++;
    if (action !== 4'd7 || busy !== 1'b1) begin
      errors++; $display("FAIL midrst_pre act=%0d busy=%b, required 7 1", action, busy);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (action !== 4'd0 || busy !== 1'b0 || din !== 32'h0 || mindex !== 2'd0 ||
        prog_addr !== 5'd0 || index !== 5'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async act=%0d busy=%b din=%h mi=%0d pa=%0d idx=%0d done=%b, all required zero",
               action, busy, din, mindex, prog_addr, index, done);
    end
    @(negedge clk);
    reset = 1'b0;
    sbq.delete();
    last_idx = 5'd0;
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      checks++;
      if (action !== 4'd0 || done !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL midrst_quiet r=%0d act=%0d done=%b busy=%b, required 0 0 0", r, action, done, busy);
      end
    end
    drive_start(3, 1'b0, 2'd1);
    for (int r = 0; r <= done_rel + 2; r++) begin
      @(negedge clk);
      checks++;
      if (action !== 4'd0) begin
        if (sbq.size() == 0) begin
          errors++; $display("FAIL replay_extra r=%0d act=%0d, required none", r, action);
        end else begin
          e = sbq.pop_front();
          if (action !== e.act || index !== e.idx || din !== e.din || mindex !== exp_mindex || r != e.rel) begin
            errors++;
            $display("FAIL replay_issue r=%0d act=%0d idx=%0d din=%h mi=%0d, required act=%0d idx=%0d din=%h mi=%0d r=%0d",
                     r, action, index, din, mindex, e.act, e.idx, e.din, exp_mindex, e.rel);
          end
        end
      end
      checks++;
      if (busy !== (r <= busy_last) || done !== (r == done_rel)) begin
        errors++; $display("FAIL replay_busy_done r=%0d busy=%b done=%b, required %b %b", r, busy, done, r <= busy_last, r == done_rel);
      end
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++; $display("FAIL replay_missing %0d actions never issued, required 0", sbq.size()); sbq.delete();
    end
  endtask

  task automatic test_mindex();
    exp_t e;
    exec_ctrl = 32'hA5A5_A5A5; div = 24'h123456; pin_grps = 32'h0F0F_0F0F;
    en_mask = 4'd3; imm_instr = 16'h7777;
    drive_start(1, 1'b1, 2'd3);
    for (int r = 0; r <= done_rel + 2; r++) begin
      @(negedge clk);
      checks++;
      if (action !== 4'd0) begin
        if (sbq.size() == 0) begin
          errors++; $display("FAIL mindex_extra r=%0d act=%0d, required none", r, action);
        end else begin
          e = sbq.pop_front();
          if (action !== e.act || index !== e.idx || din !== e.din || mindex !== exp_mindex || r != e.rel) begin
            errors++;
            $display("FAIL mindex_issue r=%0d act=%0d idx=%0d din=%h mi=%0d, required act=%0d idx=%0d din=%h mi=%0d r=%0d",
                     r, action, index, din, mindex, e.act, e.idx, e.din, exp_mindex, e.rel);
          end
        end
      end
      checks++;
      if (busy !== (r <= busy_last) || done !== (r == done_rel)) begin
        errors++; $display("FAIL mindex_busy_done r=%0d busy=%b done=%b, required %b %b", r, busy, done, r <= busy_last, r == done_rel);
      end
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++; $display("FAIL mindex_missing %0d actions never issued, required 0", sbq.size()); sbq.delete();
    end
    repeat (3) @(negedge clk);
    checks++;
    if (mindex !== 2'd3 || index !== 5'd0) begin
      errors++; $display("FAIL mindex_hold mi=%0d idx=%0d, required 3 0", mindex, index);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (mindex !== 2'd0) begin
      errors++; $display("FAIL mindex_reset mi=%0d, required 0", mindex);
    end
    @(negedge clk);
    reset = 1'b0;
    last_idx = 5'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; plen = '0; sm_sel = '0; exec_ctrl = '0; div = '0;
    pin_grps = '0; en_mask = '0; imm_en = 1'b0; imm_instr = '0;
    for (int k = 0; k < 32; k++) mem[k] = 16'h9000 + 16'(k * 3);
    test_reset();
    test_basic();
    test_plen0();
    test_clamp_imm();
    test_start_ignored();
    test_reset_mid();
    test_mindex();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
